load_store_unit: RTL and testbench

//  Initiator side of the CPU data-memory bus. Takes one load/store at a time from the

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 35 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store unit.
//   SZ_*        access size encodings as carried on req_size_i / dsize_o
//   lsu_state_e FSM states of the unit
//   lsu_req_t   request fields latched at the handshake
//   be_gen      byte enables for a size/offset pair
//   wdata_rep   lane-replicated store data
//   misaligned  alignment / legality check of a request
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} lsu_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: be_gen = 4'b0001 << off;
      SZ_HALF: be_gen = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: wdata_rep = {4{data[7:0]}};
      SZ_HALF: wdata_rep = {2{data[15:0]}};
      default: wdata_rep = data;
    endcase
  endfunction

  // Illegal size is reported through the same flag as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    misaligned = ((size == SZ_HALF) && off[0]) ||
                 ((size == SZ_WORD) && (off != 2'b00)) ||
                 (size == SZ_ILL);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane out of a memory word and extends it.
//   size_i  access size (byte/half/word)
//   uns_i   1 = zero-extend, 0 = sign-extend
//   off_i   low address bits selecting the lane
//   word_i  raw memory read word
//   data_o  right-justified, extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (off_i)
      2'd0:    b = word_i[7:0];
      2'd1:    b = word_i[15:8];
      2'd2:    b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{b[7] & ~uns_i}}, b};
      SZ_HALF: data_o = {{16{h[15] & ~uns_i}}, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding initiator on the CPU data-memory bus.
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_*                     one request at a time from execute (valid/ready)
//   rsp_*                     one-cycle registered response pulse with error flags
//   daddr/dwdata/dsize/drd/dwr/dbe  registered memory strobes
//   daccept_i, drdata_i       memory accept and read data (cycle after accept)
// ACCEPT_TIMEOUT counts ISSUE cycles; the access aborts after that many cycles
// without an accept.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ACCEPT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misalign_o,
  output logic        rsp_timeout_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  output logic [1:0]  dsize_o,
  output logic        drd_o,
  output logic        dwr_o,
  output logic [3:0]  dbe_o,
  input  logic        daccept_i,
  input  logic [31:0] drdata_i
);

  // Value of the counter during the last ISSUE cycle allowed before abort.
  localparam logic [7:0] TO_LAST = 8'(ACCEPT_TIMEOUT - 1);

  lsu_state_e  state, state_d;
  lsu_req_t    req_q;
  logic [7:0]  cnt;
  logic        mis_q, to_q;
  logic [31:0] rdata_q, ld_data;
  logic        hs, mis_req, to_hit;

  assign req_ready_o = (state == IDLE) & ~reset_i;
  assign hs          = req_valid_i & req_ready_o;
  assign mis_req     = misaligned(req_size_i, req_addr_i[1:0]);
  assign to_hit      = ~daccept_i & (cnt == TO_LAST);

  lsu_load_align u_align (
    .size_i (req_q.size),
    .uns_i  (req_q.uns),
    .off_i  (req_q.addr[1:0]),
    .word_i (drdata_i),
    .data_o (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (hs) state_d = mis_req ? RESP : ISSUE;
      ISSUE:   if (daccept_i)  state_d = req_q.wr ? RESP : RDATA;
               else if (to_hit) state_d = RESP;
      RDATA:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q          <= '0;
      cnt            <= '0;
      mis_q          <= 1'b0;
      to_q           <= 1'b0;
      rdata_q        <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_misalign_o <= 1'b0;
      rsp_timeout_o  <= 1'b0;
      daddr_o        <= '0;
      dwdata_o       <= '0;
      dsize_o        <= '0;
      drd_o          <= 1'b0;
      dwr_o          <= 1'b0;
      dbe_o          <= '0;
    end else begin
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_misalign_o <= 1'b0;
      rsp_timeout_o  <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          req_q   <= '{wr: req_wr_i, size: req_size_i, uns: req_unsigned_i,
                       addr: req_addr_i, wdata: req_wdata_i};
          mis_q   <= mis_req;
          to_q    <= 1'b0;
          rdata_q <= '0;
          cnt     <= '0;
          // Misaligned requests never touch the bus.
          if (!mis_req) begin
            daddr_o  <= req_addr_i;
            dsize_o  <= req_size_i;
            dbe_o    <= be_gen(req_size_i, req_addr_i[1:0]);
            dwdata_o <= wdata_rep(req_size_i, req_wdata_i);
            drd_o    <= ~req_wr_i;
            dwr_o    <= req_wr_i;
          end
        end
        ISSUE: begin
          cnt <= 8'(cnt + 8'd1);
          if (daccept_i || to_hit) begin
            drd_o <= 1'b0;
            dwr_o <= 1'b0;
          end
          to_q <= to_hit;
        end
        RDATA: rdata_q <= ld_data;
        default: begin
          rsp_valid_o    <= 1'b1;
          rsp_rdata_o    <= rdata_q;
          rsp_misalign_o <= mis_q;
          rsp_timeout_o  <= to_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_wr_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        rsp_valid_o, rsp_misalign_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o, daddr_o, dwdata_o;
  logic [1:0]  dsize_o;
  logic        drd_o, dwr_o, daccept_i = 1'b0;
  logic [3:0]  dbe_o;
  logic [31:0] drdata_i = '0;

  load_store_unit #(.ACCEPT_TIMEOUT(T)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_misalign_o(rsp_misalign_o), .rsp_timeout_o(rsp_timeout_o),
    .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dsize_o(dsize_o),
    .drd_o(drd_o), .dwr_o(dwr_o), .dbe_o(dbe_o),
    .daccept_i(daccept_i), .drdata_i(drdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: extract the lane arithmetically and extend by value range.
  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] word);
    logic [31:0] v;
    case (size)
      2'd0: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (8 * off)) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 32'd1 << off;
      2'd1:    return 32'd3 << off;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // One full transaction; w = non-accept cycles before the memory accepts.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int w);
    logic mis, to, acc_prev, both, stable, sv_wr;
    int exp_lat, exp_iss, lat, n_iss, g;
    logic [31:0] sv_addr, sv_wd, r_data;
    logic [3:0] sv_be;
    logic [1:0] sv_sz;
    logic r_mis, r_to;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    to  = !mis && (w >= T);
    exp_lat = mis ? 1 : to ? T + 1 : wr ? 2 + w : 3 + w;
    exp_iss = mis ? 0 : to ? T : w + 1;
    g = 0;
    @(negedge clk_i);
    while (!req_ready_o && g < 20) begin @(negedge clk_i); g++; end
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_wr_i = wr; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_wdata_i = $urandom; req_addr_i = $urandom;
    lat = -1; n_iss = 0; acc_prev = 0; both = 0; stable = 1;
    sv_wr = 0; sv_addr = 0; sv_wd = 0; sv_be = 0; sv_sz = 0;
    r_data = 0; r_mis = 0; r_to = 0;
    for (int k = 0; k <= 20; k++) begin
      drdata_i = acc_prev ? rword : $urandom;
      acc_prev = 0; daccept_i = 1'b0;
      if (drd_o && dwr_o) both = 1;
      if (drd_o || dwr_o) begin
        n_iss++;
        if (n_iss == 1) begin
          sv_addr = daddr_o; sv_wd = dwdata_o; sv_be = dbe_o; sv_sz = dsize_o; sv_wr = dwr_o;
        end else if (daddr_o != sv_addr || dwdata_o != sv_wd || dbe_o != sv_be ||
                     dsize_o != sv_sz || dwr_o != sv_wr) stable = 0;
        if (n_iss == w + 1) begin daccept_i = 1'b1; acc_prev = 1; end
      end
      if (rsp_valid_o) begin
        lat = k; r_data = rsp_rdata_o; r_mis = rsp_misalign_o; r_to = rsp_timeout_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    daccept_i = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".strobe_cycles"}, 32'(n_iss), 32'(exp_iss));
    chk({tag, ".rdata"}, r_data, (wr || mis || to) ? 32'd0 : exp_load(size, uns, addr[1:0], rword));
    chk({tag, ".misalign"}, 32'(r_mis), 32'(mis));
    chk({tag, ".timeout"}, 32'(r_to), 32'(to));
    chk({tag, ".rd_wr_excl"}, 32'(both), 32'd0);
    if (exp_iss > 0) begin
      chk({tag, ".daddr"}, sv_addr, addr);
      chk({tag, ".dbe"}, 32'(sv_be), exp_be(size, addr[1:0]));
      chk({tag, ".dsize"}, 32'(sv_sz), 32'(size));
      chk({tag, ".dwr"}, 32'(sv_wr), 32'(wr));
      chk({tag, ".stable"}, 32'(stable), 32'd1);
      if (wr) chk({tag, ".dwdata"}, sv_wd, exp_wd(size, wdata));
    end
    @(posedge clk_i); #1;
    chk({tag, ".rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    logic noresp;
    // Reset state
    @(posedge clk_i); #1;
    chk("rst.ready", 32'(req_ready_o), 32'd0);
    chk("rst.bus", {daddr_o | dwdata_o}, 32'd0);
    chk("rst.ctl", {19'd0, dsize_o, drd_o, dwr_o, dbe_o, rsp_valid_o, rsp_misalign_o, rsp_timeout_o}, 32'd0);
    chk("rst.rdata", rsp_rdata_o, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    #1 chk("rst.ready_rel", 32'(req_ready_o), 32'd1);

    // Directed cases
    do_req("sb",  1'b1, 2'd0, 1'b0, 32'h0001_0403, 32'hAABB_CC5A, 32'h0, 0);
    do_req("lb",  1'b0, 2'd0, 1'b0, 32'h0001_0402, 32'h0, 32'h1280_FF00, 0);
    do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h0001_0402, 32'h0, 32'h1280_FF00, 0);
    do_req("lh",  1'b0, 2'd1, 1'b0, 32'h0001_0402, 32'h0, 32'h8001_1234, 0);
    do_req("lw",  1'b0, 2'd2, 1'b0, 32'h0001_0400, 32'h0, 32'h8001_1234, 0);
    do_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0001_0401, 32'h0, 32'h0, 0);
    do_req("sh_mis", 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h1234, 32'h0, 0);
    do_req("sz3", 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0);
    do_req("sw_wait3", 1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 3);
    do_req("sw_to", 1'b1, 2'd2, 1'b0, 32'h0000_2000, 32'h1111_2222, 32'h0, 100);
    do_req("lh_to", 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'hFFFF_FFFF, 100);
    do_req("lw_wait3", 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 32'h0BAD_F00D, 3);

    // Reset while in ISSUE
    @(negedge clk_i);
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h0000_4000;
    req_wdata_i = 32'h5555_AAAA;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst.dwr_before", 32'(dwr_o), 32'd1);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst.ready", 32'(req_ready_o), 32'd0);
    chk("midrst.bus", {daddr_o | dwdata_o}, 32'd0);
    chk("midrst.ctl", {19'd0, dsize_o, drd_o, dwr_o, dbe_o, rsp_valid_o, rsp_misalign_o, rsp_timeout_o}, 32'd0);
    reset_i = 1'b0;
    #1 chk("midrst.ready_rel", 32'(req_ready_o), 32'd1);
    noresp = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o || drd_o || dwr_o) noresp = 1'b0;
    end
    chk("midrst.quiet", 32'(noresp), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, T - 1));
      do_req($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
